jk_bank_arbiter: RTL and testbench
==================================

// Module: jk_bank_arbiter
// PURPOSE
//  Shares one W-bit register bank built from JK flip-flops between two requesters.
//  Each requester issues a SET, CLEAR, TOGGLE or LOAD command under a bit mask.
//  A round-robin arbiter picks one command at a time. A 3-state FSM converts the
//  granted command into per-bit J/K drives for one clock, then acknowledges it.
//  Sits between control logic and the flip-flop bank; this is the sequencer for the JK datapath.
// PARAMETERS
//  W         8   width of register bank (number of JK flops)
// PORTS
//  clk    in   1  clock; all state changes on posedge
//  rst    in   1  synchronous, active-low reset
//  req0   in   1  requester 0 command request
//  op0    in   2  requester 0 opcode (see BEHAVIOUR)
//  mask0  in   W  requester 0 bit mask; only bits with mask=1 are affected
//  data0  in   W  requester 0 load data (used by LOAD only)
//  req1   in   1  requester 1 command request
//  op1    in   2  requester 1 opcode
//  mask1  in   W  requester 1 bit mask
//  data1  in   W  requester 1 load data
//  gnt0   out  1  requester 0 command accepted and executing
//  gnt1   out  1  requester 1 command accepted and executing
//  done0  out  1  one-cycle pulse: requester 0 command complete, q updated
//  done1  out  1  one-cycle pulse: requester 1 command complete, q updated
//  busy   out  1  high whenever FSM is not IDLE
//  q      out  W  register bank state
//  qb     out  W  ~q
// BEHAVIOUR
//  Reset (rst=0 at posedge): q=0, qb=all 1s, gnt*=0, done*=0, busy=0, state=IDLE, rr_ptr=0.
//   Reset overrides everything, including reset mid-command: the command is dropped and no done is pulsed.
//  Opcodes (per masked bit): SET=2'b00 J=1,K=0; CLEAR=2'b01 J=0,K=1;
//   TOGGLE=2'b10 J=1,K=1; LOAD=2'b11 J=data,K=~data.
//   Unmasked bits always get J=K=0 (hold).
//  FSM states:
//   IDLE: if any req is high at the edge, select a winner and go to EXEC; else stay in IDLE.
//    Winner: if only one req is high, that requester. If both are high, the requester named by rr_ptr.
//    The same edge captures the winner's op/mask/data into a command register.
//    Later changes on the inputs have no effect on the captured command.
//   EXEC: gnt[winner]=1 for exactly this cycle. J/K are driven from the command register.
//    At the end-of-cycle edge the bank updates. Then go to DONE.
//   DONE: done[winner]=1 for exactly this cycle; q already shows the new value.
//    rr_ptr <= ~winner. Go to IDLE.
//  Outside EXEC, the bank sees J=K=0 on all bits, so q holds.
//  Latency: req sampled at edge t; gnt high in cycle t+1; q new and done high in cycle t+2.
//   The next request is sampled at edge t+3, so throughput is one command per 3 cycles.
//  A requester must drop req in its done cycle; if req is still high in IDLE it is treated as a new command.
//  Fairness: with both reqs held continuously, grants alternate 0,1,0,1...
//  mask=0: full sequence still runs (gnt, then done); q is unchanged.
//  An opcode X on inputs outside a capture edge is ignored.
//  busy = (state != IDLE). gnt*, done* and busy are registered outputs (no combinational paths from inputs).
// STRUCTURE
//  Package jk_ctrl_pkg:
//   - op localparams OP_SET, OP_CLR, OP_TGL, OP_LD;
//   - state encoding S_IDLE=2'd0, S_EXEC=2'd1, S_DONE=2'd2;
//   - a function op_to_jk(op, mask, data) returning {j,k}.
//  Sub-module jk_reg_bank #(W): W JK flops with shared clk and active-low synchronous rst.
//   Inputs j[W-1:0], k[W-1:0]; outputs q and qb.
//   JK truth table: 00 hold, 01 clear, 10 set, 11 toggle.
//  Top level: arbiter + rr_ptr, command register, FSM, J/K decode.
// TESTING
//  1 Reset: hold rst=0 for 2 cycles with req0=req1=1.
//    -> q=8'h00, qb=8'hFF, gnt*=done*=busy=0.
//  2 Basic: req0 SET mask=8'h0F, 1 cycle.
//    -> gnt0 next cycle; the cycle after, done0=1 and q=8'h0F; busy high for exactly 2 cycles.
//  3 Toggle: from q=8'h0F, req1 TOGGLE mask=8'hFF.
//    -> q=8'hF0 when done1 is high; gnt0 and done0 stay 0.
//  4 Contention after reset: req0 LOAD data=8'hA5 mask=8'hFF; req1 CLEAR mask=8'hFF; both held.
//    -> req0 served first (q=8'hA5), then req1 (q=8'h00), then req0 again (q=8'hA5).
//  5 Mid-op reset: rst=0 during EXEC of a SET 8'hFF.
//    -> no done, q=8'h00, state IDLE; a following SET 8'h01 completes normally.
//  6 Masks: TOGGLE with mask=8'h00 from q=8'h3C -> done pulses, q stays 8'h3C.
//    LOAD data=8'hFF mask=8'h81 from q=8'h3C -> q=8'hBD.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared opcodes, FSM states and J/K decode
// for the JK register bank sequencer.
package jk_ctrl_pkg;

  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_TGL = 2'b10;
  localparam logic [1:0] OP_LD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Per-bit decode: returns {j,k}; unmasked bits hold
  function automatic logic [1:0] op_to_jk(
    input logic [1:0] op,
    input logic       mask,
    input logic       data
  );
    logic [1:0] jk;
    jk = 2'b00;
    if (mask) begin
      case (op)
        OP_SET:  jk = 2'b10;
        OP_CLR:  jk = 2'b01;
        OP_TGL:  jk = 2'b11;
        OP_LD:   jk = {data, ~data};
        default: jk = 2'b00;
      endcase
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// Bank of W JK flip-flops with shared clock
// and synchronous active-low reset.
module jk_reg_bank #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] j,
  input  logic [W-1:0] k,
  output logic [W-1:0] q,
  output logic [W-1:0] qb
);

  logic [W-1:0] r_q;

  // JK next state: q+ = j&~q | ~k&q
  always_ff @(posedge clk) begin
    if (!rst) r_q <= '0;
    else      r_q <= (j & ~r_q) | (~k & r_q);
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter and 3-state sequencer
// driving a shared JK register bank.
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] mask0,
  input  logic [W-1:0] data0,
  input  logic         req1,
  input  logic [1:0]   op1,
  input  logic [W-1:0] mask1,
  input  logic [W-1:0] data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         busy,
  output logic [W-1:0] q,
  output logic [W-1:0] qb
);

  state_t       r_state;
  logic         r_win;
  logic         r_rr;
  logic [1:0]   r_op;
  logic [W-1:0] r_mask;
  logic [W-1:0] r_data;
  logic         r_gnt0;
  logic         r_gnt1;
  logic         r_done0;
  logic         r_done1;
  logic         r_busy;

  logic         w_pick;
  logic [W-1:0] w_j;
  logic [W-1:0] w_k;

  // Single requester wins outright; on a tie rr_ptr decides
  assign w_pick = (req0 & req1) ? r_rr : req1;

  // Sequencer: capture in IDLE, drive J/K in EXEC, pulse done in DONE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_win   <= 1'b0;
      r_rr    <= 1'b0;
      r_op    <= OP_SET;
      r_mask  <= '0;
      r_data  <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_win   <= w_pick;
            r_op    <= w_pick ? op1   : op0;
            r_mask  <= w_pick ? mask1 : mask0;
            r_data  <= w_pick ? data1 : data0;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= ~r_win;
          r_done1 <= r_win;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_rr    <= ~r_win;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bank only sees a live command during EXEC
  for (genvar gi = 0; gi < W; gi++) begin : g_jk
    assign {w_j[gi], w_k[gi]} = (r_state == S_EXEC)
      ? op_to_jk(r_op, r_mask[gi], r_data[gi])
      : 2'b00;
  end

  jk_reg_bank #(.W(W)) u_bank (
    .clk (clk),
    .rst (rst),
    .j   (w_j),
    .k   (w_k),
    .q   (q),
    .qb  (qb)
  );

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign busy  = r_busy;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter:
// hand-computed vectors, immediate assertions.
module tb_jk_bank_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic [1:0] op0;
  logic [7:0] mask0;
  logic [7:0] data0;
  logic       req1;
  logic [1:0] op1;
  logic [7:0] mask1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic       busy;
  logic [7:0] q;
  logic [7:0] qb;

  int checks = 0;
  int errors = 0;

  jk_bank_arbiter #(.W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .op0   (op0),
    .mask0 (mask0),
    .data0 (data0),
    .req1  (req1),
    .op1   (op1),
    .mask1 (mask1),
    .data1 (data1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .q     (q),
    .qb    (qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // One command from one requester, checked
  // through gnt, done and final q; inputs go X
  // after the capture edge and must be ignored.
  task automatic cmd(
    input string      tag,
    input logic       who,
    input logic [1:0] op,
    input logic [7:0] mask,
    input logic [7:0] data,
    input logic [7:0] qexp
  );
    if (who) begin
      req1 = 1'b1; op1 = op;
      mask1 = mask; data1 = data;
    end else begin
      req0 = 1'b1; op0 = op;
      mask0 = mask; data0 = data;
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    op0 = 'x; op1 = 'x;
    mask0 = 'x; mask1 = 'x;
    data0 = 'x; data1 = 'x;
    chk({tag, "_gnt"},
        {6'd0, gnt1, gnt0},
        {6'd0, who, ~who});
    @(negedge clk);
    chk({tag, "_done"},
        {6'd0, done1, done0},
        {6'd0, who, ~who});
    chk({tag, "_q"}, q, qexp);
    @(negedge clk);
    chk({tag, "_idle"},
        {5'd0, busy, done1, done0}, 8'h00);
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b1; op0 = 2'b00;
    mask0 = 8'hFF; data0 = 8'h00;
    req1 = 1'b1; op1 = 2'b00;
    mask1 = 8'hFF; data1 = 8'h00;

    // 1 Reset with both requests asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", q, 8'h00);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_ctl",
        {3'd0, busy, done1, done0, gnt1, gnt0},
        8'h00);
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", {7'd0, busy}, 8'h00);

    // 2 Basic SET by requester 0
    req0 = 1'b1; op0 = 2'b00;
    mask0 = 8'h0F; data0 = 8'h00;
    @(negedge clk);
    req0 = 1'b0;
    chk("set_gnt0", {7'd0, gnt0}, 8'h01);
    chk("set_busy1", {7'd0, busy}, 8'h01);
    chk("set_nodone", {7'd0, done0}, 8'h00);
    chk("set_q_hold", q, 8'h00);
    @(negedge clk);
    chk("set_done0", {7'd0, done0}, 8'h01);
    chk("set_q", q, 8'h0F);
    chk("set_busy2", {7'd0, busy}, 8'h01);
    chk("set_gnt_off", {7'd0, gnt0}, 8'h00);
    @(negedge clk);
    chk("set_busy_off", {7'd0, busy}, 8'h00);
    chk("set_done_off", {7'd0, done0}, 8'h00);

    // 3 TOGGLE by requester 1
    cmd("tgl", 1'b1, 2'b10, 8'hFF, 8'h00, 8'hF0);
    chk("tgl_qb", qb, 8'h0F);

    // 4 Contention after reset, both held
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("c_rst_q", q, 8'h00);
    req0 = 1'b1; op0 = 2'b11;
    mask0 = 8'hFF; data0 = 8'hA5;
    req1 = 1'b1; op1 = 2'b01;
    mask1 = 8'hFF; data1 = 8'h00;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("c_gnt",
          {6'd0, gnt1, gnt0},
          (n == 1) ? 8'h02 : 8'h01);
      @(negedge clk);
      chk("c_done",
          {6'd0, done1, done0},
          (n == 1) ? 8'h02 : 8'h01);
      chk("c_q", q,
          (n == 1) ? 8'h00 : 8'hA5);
      if (n == 2) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
      chk("c_gap", {7'd0, busy}, 8'h00);
    end
    @(negedge clk);
    chk("c_quiet", {7'd0, busy}, 8'h00);

    // 5 Reset during EXEC of SET 8'hFF
    req0 = 1'b1; op0 = 2'b00;
    mask0 = 8'hFF; data0 = 8'h00;
    @(negedge clk);
    chk("mr_gnt0", {7'd0, gnt0}, 8'h01);
    req0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_q", q, 8'h00);
    chk("mr_ctl",
        {3'd0, busy, done1, done0, gnt1, gnt0},
        8'h00);
    @(negedge clk);
    chk("mr_nodone",
        {5'd0, busy, done1, done0}, 8'h00);
    chk("mr_q2", q, 8'h00);
    cmd("mr_set", 1'b0, 2'b00, 8'h01, 8'h00, 8'h01);

    // 6 Masks
    cmd("m_ld", 1'b1, 2'b11, 8'hFF, 8'h3C, 8'h3C);
    cmd("m_zero", 1'b0, 2'b10, 8'h00, 8'h00, 8'h3C);
    cmd("m_81", 1'b1, 2'b11, 8'h81, 8'hFF, 8'hBD);
    chk("m_qb", qb, 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
